// File: rtl/mem_arbiter.sv
//============================================================================
// Module  : mem_arbiter
// Brief   : Shares one memory bus between the fetch and data ports. The data
//           port has fixed priority. A wait counter aborts transactions that
//           the memory never acknowledges.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  // data port
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  // memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  // status
  output logic        stall_fetch,
  output logic        stall_mem,
  output logic        bus_error
);

  localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [c_cnt_w-1:0]   w_wait_cnt_nxt;
  logic                 r_cancel;
  logic                 w_cancel_nxt;

  logic                 w_mem_req_nxt;
  logic                 w_mem_we_nxt;
  logic [31:0]          w_mem_addr_nxt;
  logic [31:0]          w_mem_wdata_nxt;
  logic [3:0]           w_mem_wstrb_nxt;
  logic [31:0]          w_if_rdata_nxt;
  logic                 w_if_ready_nxt;
  logic [31:0]          w_dm_rdata_nxt;
  logic                 w_dm_ready_nxt;
  logic                 w_bus_error_nxt;

  logic                 w_dm_grant;
  logic                 w_if_grant;
  logic                 w_cancel_cur;
  logic                 w_timeout;
  logic [31:0]          w_cpl_rdata;

  // A requester still holds req during its ready pulse; that cycle is not a new request.
  assign w_dm_grant   = dm_req & ~dm_ready;
  assign w_if_grant   = if_req & ~if_ready & ~if_cancel;
  assign w_cancel_cur = r_cancel | if_cancel;
  assign w_timeout    = (r_wait_cnt == c_wait_limit);
  assign w_cpl_rdata  = mem_ack ? mem_rdata : 32'd0;

  assign stall_fetch  = if_req & ~if_ready & ~if_cancel;
  assign stall_mem    = dm_req & ~dm_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_cancel_nxt    = r_cancel;
    w_mem_req_nxt   = mem_req;
    w_mem_we_nxt    = mem_we;
    w_mem_addr_nxt  = mem_addr;
    w_mem_wdata_nxt = mem_wdata;
    w_mem_wstrb_nxt = mem_wstrb;
    w_if_rdata_nxt  = if_rdata;
    w_if_ready_nxt  = 1'b0;
    w_dm_rdata_nxt  = dm_rdata;
    w_dm_ready_nxt  = 1'b0;
    w_bus_error_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_wait_cnt_nxt = '0;
        w_cancel_nxt   = 1'b0;
        if (w_dm_grant) begin
          w_state_nxt     = DM_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = dm_we;
          w_mem_addr_nxt  = dm_addr;
          w_mem_wdata_nxt = dm_wdata;
          w_mem_wstrb_nxt = dm_wstrb;
        end else if (w_if_grant) begin
          w_state_nxt     = IF_BUSY;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr;
          w_mem_wdata_nxt = 32'd0;
          w_mem_wstrb_nxt = 4'd0;
        end
      end

      IF_BUSY, DM_BUSY: begin
        // An ack in the last allowed cycle still counts as a normal completion.
        if (mem_ack || w_timeout) begin
          w_state_nxt     = IDLE;
          w_mem_req_nxt   = 1'b0;
          w_wait_cnt_nxt  = '0;
          w_cancel_nxt    = 1'b0;
          w_bus_error_nxt = ~mem_ack;
          if (r_state == DM_BUSY) begin
            w_dm_ready_nxt = 1'b1;
            w_dm_rdata_nxt = w_cpl_rdata;
          end else if (!w_cancel_cur) begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = w_cpl_rdata;
          end
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_cnt_w'(1);
          if (r_state == IF_BUSY) begin
            w_cancel_nxt = w_cancel_cur;
          end
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_cancel   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'd0;
      if_rdata   <= 32'd0;
      if_ready   <= 1'b0;
      dm_rdata   <= 32'd0;
      dm_ready   <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_cancel   <= w_cancel_nxt;
      mem_req    <= w_mem_req_nxt;
      mem_we     <= w_mem_we_nxt;
      mem_addr   <= w_mem_addr_nxt;
      mem_wdata  <= w_mem_wdata_nxt;
      mem_wstrb  <= w_mem_wstrb_nxt;
      if_rdata   <= w_if_rdata_nxt;
      if_ready   <= w_if_ready_nxt;
      dm_rdata   <= w_dm_rdata_nxt;
      dm_ready   <= w_dm_ready_nxt;
      bus_error  <= w_bus_error_nxt;
    end
  end

endmodule

`default_nettype wire
